// File: rtl/keynsham_gpio_pkg.sv
// rtl/keynsham_gpio_pkg.sv - shared register indices and helpers for the keynsham GPIO block
package keynsham_gpio_pkg;

    // Word index of each register within the 8-word window (bus_addr[2:0])
    typedef enum logic [2:0] {
        REG_OUT        = 3'd0,
        REG_OUT_SET    = 3'd1,
        REG_OUT_CLR    = 3'd2,
        REG_OE         = 3'd3,
        REG_IN         = 3'd4,
        REG_RISE_EN    = 3'd5,
        REG_FALL_EN    = 3'd6,
        REG_IRQ_STATUS = 3'd7
    } gpio_reg_e;

    // Expand the four byte-lane enables into a 32-bit bit mask
    function automatic logic [31:0] lane_mask(input logic [3:0] bytesel);
        return {{8{bytesel[3]}}, {8{bytesel[2]}}, {8{bytesel[1]}}, {8{bytesel[0]}}};
    endfunction

endpackage

// File: rtl/keynsham_sync2.sv
// rtl/keynsham_sync2.sv - parameterised-width two-flop input synchroniser
module keynsham_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops so a metastable first stage has a full cycle to settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keynsham_gpio.sv
// rtl/keynsham_gpio.sv - memory-mapped GPIO with output/enable registers and edge interrupts
module keynsham_gpio
    import keynsham_gpio_pkg::*;
#(
    parameter logic [31:0] bus_address = 32'h0,
    parameter int          bus_size    = 32,
    parameter int          num_gpio    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bus_access,
    output logic                bus_cs,
    input  logic [29:0]         bus_addr,
    input  logic [31:0]         bus_wr_val,
    input  logic                bus_wr_en,
    input  logic [3:0]          bus_bytesel,
    output logic                bus_error,
    output logic                bus_ack,
    output logic [31:0]         bus_data,
    input  logic [num_gpio-1:0] gpio_in,
    output logic [num_gpio-1:0] gpio_out,
    output logic [num_gpio-1:0] gpio_oe,
    output logic                irq
);

    localparam logic [31:0] LP_BASE_W = bus_address >> 2;
    localparam logic [31:0] LP_END_W  = (bus_address + 32'(bus_size)) >> 2;

    logic [num_gpio-1:0] r_out;
    logic [num_gpio-1:0] r_oe;
    logic [num_gpio-1:0] r_rise_en;
    logic [num_gpio-1:0] r_fall_en;
    logic [num_gpio-1:0] r_irq_status;
    logic [num_gpio-1:0] r_prev;
    logic                r_irq;
    logic                r_ack;
    logic                r_err;
    logic [31:0]         r_data;

    logic                w_hit;
    logic                w_wr;
    gpio_reg_e           w_idx;
    logic [31:0]         w_lanes_full;
    logic [num_gpio-1:0] w_lanes;
    logic [num_gpio-1:0] w_wval;
    logic [num_gpio-1:0] w_wdata;
    logic [num_gpio-1:0] w_sync;
    logic [num_gpio-1:0] w_rise;
    logic [num_gpio-1:0] w_fall;
    logic [num_gpio-1:0] w_w1c;
    logic [num_gpio-1:0] w_status_next;
    logic [31:0]         w_rdata;
    logic                w_unused_bits;

    assign bus_cs = ({2'b00, bus_addr} >= LP_BASE_W) && ({2'b00, bus_addr} < LP_END_W);

    assign w_hit        = bus_access & bus_cs;
    assign w_wr         = w_hit & bus_wr_en;
    assign w_idx        = gpio_reg_e'(bus_addr[2:0]);
    assign w_lanes_full = lane_mask(bus_bytesel);
    assign w_lanes      = w_lanes_full[num_gpio-1:0];
    assign w_wval       = bus_wr_val[num_gpio-1:0];
    assign w_wdata      = w_wval & w_lanes;

    // Bits above num_gpio are deliberately dropped on writes
    assign w_unused_bits = ^{bus_wr_val, w_lanes_full};

    keynsham_sync2 #(
        .WIDTH(num_gpio)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .i_d  (gpio_in),
        .o_q  (w_sync)
    );

    assign w_rise        = w_sync & ~r_prev & r_rise_en;
    assign w_fall        = ~w_sync & r_prev & r_fall_en;
    assign w_w1c         = (w_wr && (w_idx == REG_IRQ_STATUS)) ? w_wdata : '0;
    // New edges are ORed in after the clear so a same-cycle edge is never lost
    assign w_status_next = (r_irq_status & ~w_w1c) | w_rise | w_fall;

    // Read mux from the current (pre-write) register state; write-only registers read 0
    always_comb begin
        w_rdata = '0;
        case (w_idx)
            REG_OUT:        w_rdata[num_gpio-1:0] = r_out;
            REG_OE:         w_rdata[num_gpio-1:0] = r_oe;
            REG_IN:         w_rdata[num_gpio-1:0] = w_sync;
            REG_RISE_EN:    w_rdata[num_gpio-1:0] = r_rise_en;
            REG_FALL_EN:    w_rdata[num_gpio-1:0] = r_fall_en;
            REG_IRQ_STATUS: w_rdata[num_gpio-1:0] = r_irq_status;
            default:        w_rdata = '0;
        endcase
    end

    // Byte-lane-masked register writes, committed on the same edge that raises bus_ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out     <= '0;
            r_oe      <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (w_wr) begin
            case (w_idx)
                REG_OUT:     r_out     <= (r_out & ~w_lanes) | w_wdata;
                REG_OUT_SET: r_out     <= r_out | w_wdata;
                REG_OUT_CLR: r_out     <= r_out & ~w_wdata;
                REG_OE:      r_oe      <= (r_oe & ~w_lanes) | w_wdata;
                REG_RISE_EN: r_rise_en <= (r_rise_en & ~w_lanes) | w_wdata;
                REG_FALL_EN: r_fall_en <= (r_fall_en & ~w_lanes) | w_wdata;
                default:     ;
            endcase
        end
    end

    // Edge history and sticky interrupt status; irq tracks the status on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev       <= '0;
            r_irq_status <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_prev       <= w_sync;
            r_irq_status <= w_status_next;
            r_irq        <= |w_status_next;
        end
    end

    // Single-cycle bus response; read data is zero outside the ack cycle so slaves can be ORed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_data <= '0;
        end else begin
            r_ack  <= w_hit;
            r_err  <= w_wr && (w_idx == REG_IN);
            r_data <= (w_hit && !bus_wr_en) ? w_rdata : 32'h0;
        end
    end

    assign bus_ack   = r_ack;
    assign bus_error = r_err;
    assign bus_data  = r_data;
    assign gpio_out  = r_out;
    assign gpio_oe   = r_oe;
    assign irq       = r_irq;

endmodule
